// File: rtl/placement_checker_pkg.sv
// Shared definitions for the placement read-back checker: status codes,
// the empty-cell sentinel and the checker state enumeration.
package placement_checker_pkg;

  localparam logic [2:0] STATUS_OK       = 3'd0;
  localparam logic [2:0] STATUS_UNPLACED = 3'd1;
  localparam logic [2:0] STATUS_RANGE    = 3'd2;
  localparam logic [2:0] STATUS_MISMATCH = 3'd3;
  localparam logic [2:0] STATUS_COUNT    = 3'd4;

  localparam logic signed [31:0] EMPTY = -32'sd1;

  typedef enum logic [3:0] {
    IDLE,
    N_RD,
    N_CAP,
    G1_RD,
    G1_CHK,
    G2_RD,
    G2_CAP,
    G2_CHK,
    E_RD,
    E_CAP,
    A_RD,
    A_CAP,
    B_RD,
    B_CAP,
    E_ACC,
    DONE
  } state_t;

endpackage

// File: rtl/placement_checker_if.sv
// Read-only port bundle to the placement memories: edge ROMs (ea/eb),
// position RAMs (px/py) and the grid RAM. Read data follows its strobe by one cycle.
interface placement_checker_if;

  logic               ea_re;
  logic               eb_re;
  logic               px_re;
  logic               py_re;
  logic               grid_re;
  logic        [31:0] ea_addr;
  logic        [31:0] eb_addr;
  logic        [31:0] px_addr;
  logic        [31:0] py_addr;
  logic        [31:0] grid_addr;
  logic signed [31:0] ea_dout;
  logic signed [31:0] eb_dout;
  logic signed [31:0] px_dout;
  logic signed [31:0] py_dout;
  logic signed [31:0] grid_dout;

  modport master (
    output ea_re, eb_re, px_re, py_re, grid_re,
    output ea_addr, eb_addr, px_addr, py_addr, grid_addr,
    input  ea_dout, eb_dout, px_dout, py_dout, grid_dout
  );

  modport slave (
    input  ea_re, eb_re, px_re, py_re, grid_re,
    input  ea_addr, eb_addr, px_addr, py_addr, grid_addr,
    output ea_dout, eb_dout, px_dout, py_dout, grid_dout
  );

endinterface

// File: rtl/placement_checker_manhattan_cost.sv
// Combinational edge cost between two placed nodes: Manhattan distance minus one,
// and the 1-hop variant where each axis costs ceil(|d|/2).
module manhattan_cost (
  input  logic signed [31:0] xa,
  input  logic signed [31:0] ya,
  input  logic signed [31:0] xb,
  input  logic signed [31:0] yb,
  output logic signed [31:0] cost,
  output logic signed [31:0] cost_1hop
);

  logic signed [31:0] dx;
  logic signed [31:0] dy;
  logic        [31:0] adx;
  logic        [31:0] ady;
  logic        [31:0] hx;
  logic        [31:0] hy;

  assign dx = xa - xb;
  assign dy = ya - yb;

  // Two's-complement negation; wraps silently for the most negative value.
  assign adx = dx[31] ? (~dx + 32'd1) : dx;
  assign ady = dy[31] ? (~dy + 32'd1) : dy;

  assign hx = {1'b0, adx[31:1]} + {31'b0, adx[0]};
  assign hy = {1'b0, ady[31:1]} + {31'b0, ady[0]};

  assign cost      = $signed(adx + ady - 32'd1);
  assign cost_1hop = $signed(hx + hy - 32'd1);

endmodule

// File: rtl/placement_checker.sv
// Walks the finished placement memories: verifies every node against the grid,
// cross-checks grid occupancy, then sums Manhattan and 1-hop wirelength over the edges.
module placement_checker
  import placement_checker_pkg::*;
#(
  parameter int N      = 10,
  parameter int N_NODE = 100,
  parameter int N_EDGE = 96
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic         [2:0]  status,
  output logic         [31:0] err_index,
  output logic signed  [31:0] wl,
  output logic signed  [31:0] wl_1hop,
  output logic         [31:0] occupied,
  placement_checker_if.master mem
);

  localparam logic signed [31:0] N_S       = 32'(N);
  localparam logic        [31:0] LAST_NODE = 32'(N_NODE - 1);
  localparam logic        [31:0] LAST_CELL = 32'(N * N - 1);
  localparam logic        [31:0] LAST_EDGE = 32'(N_EDGE - 1);
  localparam logic        [31:0] N_CELLS   = 32'(N * N);

  state_t             state_reg,     state_next;
  logic        [31:0] node_idx_reg,  node_idx_next;
  logic        [31:0] cell_idx_reg,  cell_idx_next;
  logic        [31:0] edge_idx_reg,  edge_idx_next;
  logic        [31:0] pass_cnt_reg,  pass_cnt_next;
  logic        [31:0] occupied_reg,  occupied_next;
  logic        [31:0] node_a_reg,    node_a_next;
  logic        [31:0] node_b_reg,    node_b_next;
  logic signed [31:0] xa_reg,        xa_next;
  logic signed [31:0] ya_reg,        ya_next;
  logic signed [31:0] xb_reg,        xb_next;
  logic signed [31:0] yb_reg,        yb_next;
  logic signed [31:0] grid_val_reg,  grid_val_next;
  logic               chk_phase_reg, chk_phase_next;
  logic        [2:0]  status_reg,    status_next;
  logic        [31:0] err_index_reg, err_index_next;
  logic signed [31:0] wl_reg,        wl_next;
  logic signed [31:0] wl_1hop_reg,   wl_1hop_next;

  logic signed [31:0] edge_cost;
  logic signed [31:0] edge_cost_1hop;
  logic        [31:0] grid_cell;

  manhattan_cost u_cost (
    .xa        (xa_reg),
    .ya        (ya_reg),
    .xb        (xb_reg),
    .yb        (yb_reg),
    .cost      (edge_cost),
    .cost_1hop (edge_cost_1hop)
  );

  assign grid_cell = 32'(xa_reg * N_S + ya_reg);

  assign busy      = (state_reg != IDLE) && (state_reg != DONE);
  assign done      = (state_reg == DONE);
  assign status    = status_reg;
  assign err_index = err_index_reg;
  assign wl        = wl_reg;
  assign wl_1hop   = wl_1hop_reg;
  assign occupied  = occupied_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      node_idx_reg  <= '0;
      cell_idx_reg  <= '0;
      edge_idx_reg  <= '0;
      pass_cnt_reg  <= '0;
      occupied_reg  <= '0;
      node_a_reg    <= '0;
      node_b_reg    <= '0;
      xa_reg        <= '0;
      ya_reg        <= '0;
      xb_reg        <= '0;
      yb_reg        <= '0;
      grid_val_reg  <= '0;
      chk_phase_reg <= 1'b0;
      status_reg    <= STATUS_OK;
      err_index_reg <= '0;
      wl_reg        <= '0;
      wl_1hop_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      node_idx_reg  <= node_idx_next;
      cell_idx_reg  <= cell_idx_next;
      edge_idx_reg  <= edge_idx_next;
      pass_cnt_reg  <= pass_cnt_next;
      occupied_reg  <= occupied_next;
      node_a_reg    <= node_a_next;
      node_b_reg    <= node_b_next;
      xa_reg        <= xa_next;
      ya_reg        <= ya_next;
      xb_reg        <= xb_next;
      yb_reg        <= yb_next;
      grid_val_reg  <= grid_val_next;
      chk_phase_reg <= chk_phase_next;
      status_reg    <= status_next;
      err_index_reg <= err_index_next;
      wl_reg        <= wl_next;
      wl_1hop_reg   <= wl_1hop_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    node_idx_next  = node_idx_reg;
    cell_idx_next  = cell_idx_reg;
    edge_idx_next  = edge_idx_reg;
    pass_cnt_next  = pass_cnt_reg;
    occupied_next  = occupied_reg;
    node_a_next    = node_a_reg;
    node_b_next    = node_b_reg;
    xa_next        = xa_reg;
    ya_next        = ya_reg;
    xb_next        = xb_reg;
    yb_next        = yb_reg;
    grid_val_next  = grid_val_reg;
    chk_phase_next = chk_phase_reg;
    status_next    = status_reg;
    err_index_next = err_index_reg;
    wl_next        = wl_reg;
    wl_1hop_next   = wl_1hop_reg;
    mem.ea_re      = 1'b0;
    mem.eb_re      = 1'b0;
    mem.px_re      = 1'b0;
    mem.py_re      = 1'b0;
    mem.grid_re    = 1'b0;
    mem.ea_addr    = '0;
    mem.eb_addr    = '0;
    mem.px_addr    = '0;
    mem.py_addr    = '0;
    mem.grid_addr  = '0;

    unique case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next     = N_RD;
          node_idx_next  = '0;
          cell_idx_next  = '0;
          edge_idx_next  = '0;
          pass_cnt_next  = '0;
          occupied_next  = '0;
          chk_phase_next = 1'b0;
          status_next    = STATUS_OK;
          err_index_next = '0;
          wl_next        = '0;
          wl_1hop_next   = '0;
        end
      end
      N_RD: begin
        mem.px_re   = 1'b1;
        mem.py_re   = 1'b1;
        mem.px_addr = node_idx_reg;
        mem.py_addr = node_idx_reg;
        state_next  = N_CAP;
      end
      N_CAP: begin
        xa_next = mem.px_dout;
        ya_next = mem.py_dout;
        if (mem.px_dout == EMPTY || mem.py_dout == EMPTY) begin
          status_next    = STATUS_UNPLACED;
          err_index_next = node_idx_reg;
          state_next     = DONE;
        end else if (mem.px_dout < 0 || mem.px_dout >= N_S ||
                     mem.py_dout < 0 || mem.py_dout >= N_S) begin
          status_next    = STATUS_RANGE;
          err_index_next = node_idx_reg;
          state_next     = DONE;
        end else begin
          state_next = G1_RD;
        end
      end
      G1_RD: begin
        mem.grid_re    = 1'b1;
        mem.grid_addr  = grid_cell;
        chk_phase_next = 1'b0;
        state_next     = G1_CHK;
      end
      G1_CHK: begin
        // First cycle registers the grid word, second cycle compares it.
        if (!chk_phase_reg) begin
          grid_val_next  = mem.grid_dout;
          chk_phase_next = 1'b1;
        end else begin
          chk_phase_next = 1'b0;
          if (grid_val_reg != $signed(node_idx_reg)) begin
            status_next    = STATUS_MISMATCH;
            err_index_next = node_idx_reg;
            state_next     = DONE;
          end else begin
            pass_cnt_next = pass_cnt_reg + 32'd1;
            if (node_idx_reg == LAST_NODE) begin
              cell_idx_next = '0;
              state_next    = G2_RD;
            end else begin
              node_idx_next = node_idx_reg + 32'd1;
              state_next    = N_RD;
            end
          end
        end
      end
      G2_RD: begin
        // One read per cycle; the word returning now belongs to the previous cell.
        mem.grid_re   = 1'b1;
        mem.grid_addr = cell_idx_reg;
        if (cell_idx_reg != '0 && mem.grid_dout != EMPTY)
          occupied_next = occupied_reg + 32'd1;
        if (cell_idx_reg == LAST_CELL) begin
          state_next = G2_CAP;
        end else begin
          cell_idx_next = cell_idx_reg + 32'd1;
        end
      end
      G2_CAP: begin
        if (mem.grid_dout != EMPTY)
          occupied_next = occupied_reg + 32'd1;
        state_next = G2_CHK;
      end
      G2_CHK: begin
        if (occupied_reg != pass_cnt_reg) begin
          status_next    = STATUS_COUNT;
          err_index_next = N_CELLS;
          state_next     = DONE;
        end else begin
          edge_idx_next = '0;
          state_next    = E_RD;
        end
      end
      E_RD: begin
        mem.ea_re   = 1'b1;
        mem.eb_re   = 1'b1;
        mem.ea_addr = edge_idx_reg;
        mem.eb_addr = edge_idx_reg;
        state_next  = E_CAP;
      end
      E_CAP: begin
        node_a_next = $unsigned(mem.ea_dout);
        node_b_next = $unsigned(mem.eb_dout);
        state_next  = A_RD;
      end
      A_RD: begin
        mem.px_re   = 1'b1;
        mem.py_re   = 1'b1;
        mem.px_addr = node_a_reg;
        mem.py_addr = node_a_reg;
        state_next  = A_CAP;
      end
      A_CAP: begin
        xa_next    = mem.px_dout;
        ya_next    = mem.py_dout;
        state_next = B_RD;
      end
      B_RD: begin
        mem.px_re   = 1'b1;
        mem.py_re   = 1'b1;
        mem.px_addr = node_b_reg;
        mem.py_addr = node_b_reg;
        state_next  = B_CAP;
      end
      B_CAP: begin
        xb_next    = mem.px_dout;
        yb_next    = mem.py_dout;
        state_next = E_ACC;
      end
      E_ACC: begin
        wl_next      = wl_reg + edge_cost;
        wl_1hop_next = wl_1hop_reg + edge_cost_1hop;
        if (edge_idx_reg == LAST_EDGE) begin
          state_next = DONE;
        end else begin
          edge_idx_next = edge_idx_reg + 32'd1;
          state_next    = E_RD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_placement_checker.sv
// Directed bench for placement_checker on a 4x4 grid with 3 nodes and 2 edges:
// a table of corrupted placements plus hand-written reset/restart sequences.
module tb_placement_checker;

  localparam int N      = 4;
  localparam int N_NODE = 3;
  localparam int N_EDGE = 2;

  logic               clk;
  logic               reset;
  logic               start;
  logic               busy;
  logic               done;
  logic        [2:0]  status;
  logic        [31:0] err_index;
  logic signed [31:0] wl;
  logic signed [31:0] wl_1hop;
  logic        [31:0] occupied;

  placement_checker_if mif ();

  placement_checker #(
    .N      (N),
    .N_NODE (N_NODE),
    .N_EDGE (N_EDGE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .status    (status),
    .err_index (err_index),
    .wl        (wl),
    .wl_1hop   (wl_1hop),
    .occupied  (occupied),
    .mem       (mif)
  );

  logic signed [31:0] px_mem   [0:3];
  logic signed [31:0] py_mem   [0:3];
  logic signed [31:0] grid_mem [0:15];
  logic signed [31:0] ea_mem   [0:1];
  logic signed [31:0] eb_mem   [0:1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mif.px_re)   mif.px_dout   <= px_mem[mif.px_addr[1:0]];
    if (mif.py_re)   mif.py_dout   <= py_mem[mif.py_addr[1:0]];
    if (mif.grid_re) mif.grid_dout <= grid_mem[mif.grid_addr[3:0]];
    if (mif.ea_re)   mif.ea_dout   <= ea_mem[mif.ea_addr[0]];
    if (mif.eb_re)   mif.eb_dout   <= eb_mem[mif.eb_addr[0]];
  end

  // sel: 0 no patch, 1 px[idx]=val, 2 py[idx]=val, 3 grid[idx]=val
  typedef struct {
    int sel;
    int idx;
    int val;
    int exp_status;
    int exp_err;
    int exp_wl;
    int exp_wl1;
    int exp_occ;
    int exp_cyc;
    int exp_edge_reads;
  } vec_t;

  vec_t vecs [8];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic load_base();
    px_mem[0] = 0;  py_mem[0] = 0;
    px_mem[1] = 0;  py_mem[1] = 3;
    px_mem[2] = 3;  py_mem[2] = 3;
    px_mem[3] = 0;  py_mem[3] = 0;
    for (int i = 0; i < 16; i++) grid_mem[i] = -32'sd1;
    grid_mem[0]  = 0;
    grid_mem[3]  = 1;
    grid_mem[15] = 2;
    ea_mem[0] = 0;  eb_mem[0] = 1;
    ea_mem[1] = 1;  eb_mem[1] = 2;
  endtask

  task automatic run_case(input int id, input vec_t v, input int mid_start);
    int cyc;
    int edge_reads;
    load_base();
    case (v.sel)
      1: px_mem[v.idx]   = v.val;
      2: py_mem[v.idx]   = v.val;
      3: grid_mem[v.idx] = v.val;
      default: ;
    endcase
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    edge_reads = 0;
    chk("busy_after_start", busy, 1);
    chk("done_low_after_start", done, 0);
    while (!done && cyc < 300) begin
      edge_reads += int'(mif.ea_re);
      start = (cyc == mid_start);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_cycle", cyc, v.exp_cyc);
    chk("busy_at_done", busy, 0);
    chk("status", status, v.exp_status);
    chk("err_index", err_index, v.exp_err);
    chk("wl", wl, v.exp_wl);
    chk("wl_1hop", wl_1hop, v.exp_wl1);
    chk("occupied", occupied, v.exp_occ);
    chk("edge_reads", edge_reads, v.exp_edge_reads);
    $display("case %0d: status=%0d err_index=%0d wl=%0d wl_1hop=%0d occupied=%0d done_cycle=%0d",
             id, status, err_index, wl, wl_1hop, occupied, cyc);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_status"}, status, 0);
    chk({tag, "_err_index"}, err_index, 0);
    chk({tag, "_wl"}, wl, 0);
    chk({tag, "_wl_1hop"}, wl_1hop, 0);
    chk({tag, "_occupied"}, occupied, 0);
    chk({tag, "_strobes"}, {mif.ea_re, mif.eb_re, mif.px_re, mif.py_re, mif.grid_re}, 0);
    chk({tag, "_addrs"}, mif.ea_addr | mif.eb_addr | mif.px_addr | mif.py_addr | mif.grid_addr, 0);
  endtask

  initial begin
    vecs[0] = '{0, 0,  0, 0,  0, 4, 2, 3, 48, 2};
    vecs[1] = '{1, 1, -1, 1,  1, 0, 0, 0,  8, 0};
    vecs[2] = '{1, 2,  4, 2,  2, 0, 0, 0, 13, 0};
    vecs[3] = '{3, 3,  2, 3,  1, 0, 0, 0, 11, 0};
    vecs[4] = '{3, 5,  7, 4, 16, 0, 0, 4, 34, 0};
    vecs[5] = '{2, 0, -1, 1,  0, 0, 0, 0,  3, 0};
    vecs[6] = '{1, 0,  3, 3,  0, 0, 0, 0,  6, 0};
    vecs[7] = '{2, 2, -2, 2,  2, 0, 0, 0, 13, 0};

    load_base();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_cleared("reset");
    $display("reset: busy=%0d done=%0d status=%0d", busy, done, status);

    for (int i = 0; i < 8; i++) run_case(i, vecs[i], -1);

    // Reset in the middle of the edge phase, asserted together with start.
    load_base();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (41) @(posedge clk);
    #1;
    chk("wl_mid_run", wl, 2);
    chk("busy_mid_run", busy, 1);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    check_cleared("midreset");
    @(posedge clk); #1;
    check_cleared("midreset_idle");
    $display("mid-run reset: busy=%0d done=%0d wl=%0d", busy, done, wl);

    // Fresh run from IDLE with a stray start pulsed during the grid scan.
    run_case(8, vecs[0], 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
